// File: rtl/shift_issue_stage.sv
// shift_issue_stage: 2-entry skid-buffered issue stage computing SLL/SRL/SRA for a downstream shifter
module shift_issue_stage #(
  parameter int N = 5,
  parameter int S = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [S-1:0] in_s,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_err,
  output logic [7:0]   out_count
);

  logic         skid_v;
  logic [N-1:0] skid_a;
  logic [S-1:0] skid_s;
  logic [1:0]   skid_op;
  logic [N:0]   in_res;
  logic [N:0]   skid_res;
  logic         acc;
  logic         drain;

  // Returns {err, y}; shifts of N or more naturally flush to zero or to the sign fill
  function automatic logic [N:0] calc(input logic [N-1:0] a, input logic [S-1:0] s, input logic [1:0] op);
    calc = op == 2'd0 ? {1'b0, a << s} :
           op == 2'd1 ? {1'b0, a >> s} :
           op == 2'd2 ? {1'b0, $signed(a) >>> s} :
                        {1'b1, a};
  endfunction

  assign in_res   = calc(in_a, in_s, in_op);
  assign skid_res = calc(skid_a, skid_s, skid_op);
  assign in_ready = !skid_v;
  assign acc      = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Output register fills from skid first, then from input; new requests park in skid when output stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_err   <= 1'b0;
      out_count <= 8'd0;
      skid_v    <= 1'b0;
      skid_a    <= '0;
      skid_s    <= '0;
      skid_op   <= 2'd0;
    end else begin
      if (drain) out_count <= out_count + 8'd1;
      if (skid_v) begin
        if (drain) begin
          {out_err, out_y} <= skid_res;
          skid_v           <= 1'b0;
        end
      end else if (acc) begin
        if (!out_valid || drain) begin
          {out_err, out_y} <= in_res;
          out_valid        <= 1'b1;
        end else begin
          skid_a  <= in_a;
          skid_s  <= in_s;
          skid_op <= in_op;
          skid_v  <= 1'b1;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
